serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial multi-bit subtractor built around the half-subtractor primitive: two half subtractors plus an OR form a one-bit full subtractor, and a registered borrow is carried between cycles. The block computes `Diff = A - B` over `WIDTH` clock cycles, LSB first. It sits directly downstream of the half-subtractor cell as its first sequential consumer, and trades latency for area in datapaths that accept multi-cycle arithmetic.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 2 or more.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a subtraction; sampled on the rising edge of `clk`.
- `A` input WIDTH: minuend; captured on the accepted `start` edge.
- `B` input WIDTH: subtrahend; captured on the accepted `start` edge.
- `busy` output 1: high while the operation is in progress (state RUN).
- `done` output 1: one-cycle pulse when the result is valid.
- `Diff` output WIDTH: registered result, `A - B` modulo 2^WIDTH.
- `Borrow` output 1: registered final borrow-out; 1 when `A < B` unsigned.
- `Overflow` output 1: signed overflow flag; present only with `SERIAL_SUB_OVERFLOW_EN` defined.

## Operation
- FSM states are IDLE, RUN and DONE; reset state is IDLE.
- **IDLE:**
  - `start`=1 loads `A` and `B` into internal shift registers.
  - Clears the borrow register and the bit counter, then moves to RUN.
  - `start`=0 stays in IDLE.
- **RUN:** each cycle processes one bit, with `a`, `b` as the current LSBs of the shift registers and `bin` as the borrow register.
  - Half subtractor 1: `d1 = a^b`, `b1 = ~a&b`.
  - Half subtractor 2: `d = d1^bin`, `b2 = ~d1&bin`.
  - Borrow-out: `bout = b1|b2`.
  - Bit `d` shifts into the result register MSB-side so that after `WIDTH` shifts it is LSB-aligned.
  - `bin` is updated to `bout`; operands shift right by one; the counter increments.
  - When the counter reaches `WIDTH-1`, the last bit is processed, `Diff` and `Borrow` are updated from the result and the final `bout`, and the FSM moves to DONE.
- **DONE:** `done`=1 for exactly this one cycle, then the FSM unconditionally returns to IDLE.
- `start` while in RUN or DONE is ignored; there is no queueing and operands are not re-sampled.
- `Diff` and `Borrow` hold their last value until the next completion; they do not change during RUN.
- Counter width is `$clog2(WIDTH)`; it never wraps mid-operation.
- Reset asserted at any time, including mid-RUN:
  - Immediately forces IDLE.
  - `busy`=0, `done`=0, `Diff`=0, `Borrow`=0, borrow register and counter 0.
  - The partial result is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `Diff`=0, `Borrow`=0, `Overflow`=0.
- Edge 0 samples `start`=1 in IDLE; `busy` is high from after edge 0 through edge `WIDTH`.
- Edges 1..`WIDTH` process bits 0..`WIDTH-1`.
- `Diff` and `Borrow` become valid after edge `WIDTH`; `done` is high between edge `WIDTH` and edge `WIDTH+1`.
- Latency from start edge to `done` is `WIDTH` cycles. Minimum start-to-start spacing is `WIDTH+2` cycles.
- A `start` held continuously high restarts on the first IDLE cycle after DONE.
- `busy` and `done` are never high in the same cycle.

## Configuration
- `SERIAL_SUB_OVERFLOW_EN` defined:
  - Adds output `Overflow`, registered with `Diff` on the final RUN cycle.
  - `Overflow = (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB])`, evaluated on the captured operand sign bits.
  - Reset value 0; holds like `Diff`.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, `A`=0x05, `B`=0x03, pulse `start` -> `done` pulses 8 cycles after the start edge; `Diff`=0x02, `Borrow`=0; `busy` high for 8 cycles.
- `A`=0x03, `B`=0x05 -> `Diff`=0xFE, `Borrow`=1; then `A`=0x00, `B`=0x00 -> `Diff`=0x00, `Borrow`=0, confirming the borrow register is cleared between operations.
- `A`=0xFF, `B`=0x01 -> `Diff`=0xFE, `Borrow`=0. With the macro defined:
  - `A`=0x80, `B`=0x01 -> `Diff`=0x7F, `Overflow`=1.
  - `A`=0x7F, `B`=0x01 -> `Overflow`=0.
- Start `A`=0x10, `B`=0x01, then re-pulse `start` with `A`=0xAA, `B`=0x55 at cycle 3 of RUN -> the second start is ignored; result is `Diff`=0x0F, `Borrow`=0, with a single `done` pulse.
- Hold `start`=1 continuously with `A`=0x09, `B`=0x04 -> `done` repeats every 10 cycles; `Diff`=0x05 each time.
- Start `A`=0x20, `B`=0x30, drop `rst_n` low asynchronously at RUN cycle 4 -> outputs go to 0 immediately; after release, no `done` appears without a new `start`.

Source files
------------

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial A - B, LSB first, one bit per clock, built from two
//            half subtractors and a registered borrow. Define the macro
//            SERIAL_SUB_OVERFLOW_EN to add the signed Overflow output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    localparam int              c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    // Holds the bits produced so far; the final bit completes Diff directly.
    logic [WIDTH-2:0]     r_res;
    logic                 r_bin;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 w_d1;
    logic                 w_b1;
    logic                 w_d;
    logic                 w_b2;
    logic                 w_bout;
    logic                 w_last;
    logic [WIDTH-1:0]     w_cat;

    // Full subtractor: two half subtractors and an OR on the borrows.
    always_comb begin
        w_d1   = r_a[0] ^ r_b[0];
        w_b1   = ~r_a[0] & r_b[0];
        w_d    = w_d1 ^ r_bin;
        w_b2   = ~w_d1 & r_bin;
        w_bout = w_b1 | w_b2;
        w_last = (r_cnt == c_last);
        w_cat  = {w_d, r_res};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_sa;
    logic r_sb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_bin  <= 1'b0;
            r_cnt  <= '0;
            Diff   <= '0;
            Borrow <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            Overflow <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_res <= '0;
                        r_bin <= 1'b0;
                        r_cnt <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        r_sa  <= A[WIDTH-1];
                        r_sb  <= B[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_cat[WIDTH-1:1];
                    r_bin <= w_bout;
                    if (w_last) begin
                        // Counter stays at its last value; it is cleared on the next load.
                        Diff   <= w_cat;
                        Borrow <= w_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        Overflow <= (r_sa != r_sb) && (w_d != r_sa);
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench for serial_subtractor (WIDTH=8): vector table,
//            randomized ops against an arithmetic model, and corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             Overflow;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Diff   (Diff),
        .Borrow (Borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .Overflow (Overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain modular and signed arithmetic.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] d, output logic bo, output logic ov);
        int sa;
        int sb;
        int sd;
        d  = 8'((int'(a) - int'(b)) & 255);
        bo = (a < b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sd = sa - sb;
        ov = (sd > 127) || (sd < -128);
    endtask

    // Full operation with cycle-accurate checks. inj_at>0 re-pulses start
    // with other operands during that RUN cycle.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input int inj_at);
        logic [7:0] prev_d;
        logic       prev_b;
        prev_d = Diff;
        prev_b = Borrow;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= WIDTH; k++) begin
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("done_run", {31'd0, done}, 32'd0);
            chk("diff_hold", {24'd0, Diff}, {24'd0, prev_d});
            chk("borrow_hold", {31'd0, Borrow}, {31'd0, prev_b});
            if (k == inj_at) begin
                A = 8'hAA; B = 8'h55; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("diff", {24'd0, Diff}, {24'd0, ed});
        chk("borrow", {31'd0, Borrow}, {31'd0, eb});
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("overflow", {31'd0, Overflow}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("note: bad model overflow");
`endif
        @(posedge clk); #1;
        chk("done_single", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    vec_t vt[8];

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] md;
        logic       mb;
        logic       mo;
        int         first_done;
        int         last_done;
        int         n_done;
        int         spacing_ok;
        int         overlap;
        int         stray;

        vt[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vt[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vt[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vt[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
        vt[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vt[5] = '{8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0};
        vt[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vt[7] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {24'd0, Diff}, 32'd0);
        chk("rst_borrow", {31'd0, Borrow}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("rst_overflow", {31'd0, Overflow}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_op(vt[i].a, vt[i].b, vt[i].diff, vt[i].borrow, vt[i].ovf, 0);
        end

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            model(ra, rb, md, mb, mo);
            do_op(ra, rb, md, mb, mo, 0);
        end

        // Start during RUN must be ignored.
        do_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 3);
        stray = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        chk("ignored_start_no_rerun", stray, 0);

        // Start held high: back-to-back ops every WIDTH+2 cycles.
        @(negedge clk);
        A = 8'h09; B = 8'h04; start = 1'b1;
        first_done = -1; last_done = -1; n_done = 0; spacing_ok = 1; overlap = 0;
        for (int c = 0; c < 32; c++) begin
            @(posedge clk); #1;
            if (busy && done) overlap++;
            if (done) begin
                chk("held_diff", {24'd0, Diff}, 32'h05);
                if (first_done < 0) first_done = c;
                else if (c - last_done != WIDTH + 2) spacing_ok = 0;
                last_done = c;
                n_done++;
            end
        end
        start = 1'b0;
        chk("held_first_latency", first_done, WIDTH);
        chk("held_spacing", spacing_ok, 1);
        chk("held_count", n_done, 3);
        chk("held_no_overlap", overlap, 0);
        repeat (12) @(posedge clk);

        // Asynchronous reset mid-RUN discards the operation.
        @(negedge clk);
        A = 8'h20; B = 8'h30; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_diff", {24'd0, Diff}, 32'd0);
        chk("arst_borrow", {31'd0, Borrow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        chk("arst_no_done", stray, 0);

        do_op(8'h20, 8'h30, 8'hF0, 1'b1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
